// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and address constants for dmem_arbiter
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   // byte distance between consecutive words of a debug burst
   localparam int WORD_STRIDE = 4;

   // low address bits cleared so a burst always starts on a word boundary
   localparam int ALIGN_MASK_LOW = 3;

endpackage

// File: rtl/dmem_starve_cnt.sv
// rtl/dmem_starve_cnt.sv - wait counter and slot-steal comparator for the debug burst
module dmem_starve_cnt
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_waiting,
   output logic o_steal
);

   localparam int NB_WAIT = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [NB_WAIT-1:0] wait_cnt;

   // a steal is itself a grant, so the next slot is at least MAX_WAIT cycles away
   assign o_steal = i_waiting && (wait_cnt == NB_WAIT'(MAX_WAIT));

   // count consecutive blocked burst cycles; any grant or leaving BURST restarts the count
   always_ff @(posedge i_clk) begin
      if (i_reset || !i_waiting || o_steal) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + NB_WAIT'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter: pipeline first, debug bursts in idle slots (optional DMEM_ARB_STARVE_EN)
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NB_WIDTH = 32,
   parameter int NB_ADDR  = 9,
   parameter int NB_CNT   = 8,
   parameter int MAX_WAIT = 15
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NB_WIDTH-1:0] i_pipe_addr,
   input  logic [NB_WIDTH-1:0] i_pipe_wdata,
   input  logic                i_pipe_read,
   input  logic                i_pipe_write,
   output logic [NB_WIDTH-1:0] o_pipe_rdata,
   output logic                o_pipe_stall,
   input  logic                i_dbg_start,
   input  logic [NB_ADDR-1:0]  i_dbg_addr,
   input  logic [NB_CNT-1:0]   i_dbg_len,
   output logic                o_dbg_busy,
   output logic [NB_WIDTH-1:0] o_dbg_data,
   output logic                o_dbg_valid,
   output logic                o_dbg_done,
   output logic [NB_ADDR-1:0]  o_mem_addr,
   output logic                o_mem_we,
   output logic [NB_WIDTH-1:0] o_mem_wdata,
   input  logic [NB_WIDTH-1:0] i_mem_rdata
);

   state_t              state;
   state_t              state_next;
   logic [NB_ADDR-1:0]  burst_addr;
   logic [NB_CNT-1:0]   remaining;
   logic                pipe_req;
   logic                in_burst;
   logic                steal;
   logic                grant;
   logic                unused_pipe_addr_hi;

   assign unused_pipe_addr_hi = ^i_pipe_addr[NB_WIDTH-1:NB_ADDR];

   assign pipe_req = i_pipe_read | i_pipe_write;
   assign in_burst = (state == BURST);
   assign grant    = in_burst && (!pipe_req || steal);

`ifdef DMEM_ARB_STARVE_EN
   dmem_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_cnt (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_waiting (in_burst && pipe_req),
      .o_steal   (steal)
   );
`else
   logic unused_max_wait;

   assign unused_max_wait = (MAX_WAIT != 0);
   assign steal           = 1'b0;
`endif

   assign o_pipe_stall = steal;
   assign o_pipe_rdata = i_mem_rdata;
   assign o_dbg_busy   = (state != IDLE);
   assign o_dbg_done   = (state == DONE);

   // memory port mux: a debug grant owns the port as a read, otherwise the pipeline passes through
   always_comb begin
      o_mem_addr  = i_pipe_addr[NB_ADDR-1:0];
      o_mem_we    = i_pipe_write;
      o_mem_wdata = i_pipe_wdata;
      if (grant) begin
         o_mem_addr = burst_addr;
         o_mem_we   = 1'b0;
      end
   end

   // burst sequencing: a zero-length request goes straight to the done strobe
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_dbg_start) state_next = (i_dbg_len == '0) ? DONE : BURST;
         BURST:   if (grant && (remaining == NB_CNT'(1))) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // burst address/count and the one-cycle-late read-back register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         burst_addr  <= '0;
         remaining   <= '0;
         o_dbg_valid <= 1'b0;
         o_dbg_data  <= '0;
      end else begin
         o_dbg_valid <= grant;
         if (grant) begin
            o_dbg_data <= i_mem_rdata;
         end
         if ((state == IDLE) && i_dbg_start) begin
            burst_addr <= i_dbg_addr & ~NB_ADDR'(ALIGN_MASK_LOW);
            remaining  <= i_dbg_len;
         end else if (grant) begin
            burst_addr <= burst_addr + NB_ADDR'(WORD_STRIDE);
            remaining  <= remaining - NB_CNT'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;

   localparam int MAX_WAIT = 15;
`ifdef DMEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_pipe_addr, i_pipe_wdata, o_pipe_rdata;
   logic        i_pipe_read, i_pipe_write, o_pipe_stall;
   logic        i_dbg_start, o_dbg_busy, o_dbg_valid, o_dbg_done;
   logic [8:0]  i_dbg_addr, o_mem_addr;
   logic [7:0]  i_dbg_len;
   logic [31:0] o_dbg_data, o_mem_wdata, i_mem_rdata;
   logic        o_mem_we;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .NB_WIDTH (32),
      .NB_ADDR  (9),
      .NB_CNT   (8),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_pipe_addr  (i_pipe_addr),
      .i_pipe_wdata (i_pipe_wdata),
      .i_pipe_read  (i_pipe_read),
      .i_pipe_write (i_pipe_write),
      .o_pipe_rdata (o_pipe_rdata),
      .o_pipe_stall (o_pipe_stall),
      .i_dbg_start  (i_dbg_start),
      .i_dbg_addr   (i_dbg_addr),
      .i_dbg_len    (i_dbg_len),
      .o_dbg_busy   (o_dbg_busy),
      .o_dbg_data   (o_dbg_data),
      .o_dbg_valid  (o_dbg_valid),
      .o_dbg_done   (o_dbg_done),
      .o_mem_addr   (o_mem_addr),
      .o_mem_we     (o_mem_we),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata)
   );

   // asynchronous-read RAM attached to the arbiter
   logic [31:0] ram [0:127];
   assign i_mem_rdata = ram[o_mem_addr[8:2]];
   always @(posedge clk) if (o_mem_we) ram[o_mem_addr[8:2]] <= o_mem_wdata;

   // behavioural model: expected memory contents and burst progress
   logic [31:0] shadow [0:127];
   bit          m_busy;
   int          m_left;
   int          m_wait;
   logic [8:0]  m_addr;
   bit          m_valid;
   logic [31:0] m_data;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          done_at = -1;
   int          t0;
   logic [31:0] dq [$];
   int          stall_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic st, input logic [8:0] sa, input logic [7:0] sl, input logic rst);
      logic       req, burst, fin, stl, grant;
      logic [8:0] ea;
      i_reset = rst; i_pipe_read = rd; i_pipe_write = wr; i_pipe_addr = a; i_pipe_wdata = wd;
      i_dbg_start = st; i_dbg_addr = sa; i_dbg_len = sl;
      @(negedge clk);
      req   = rd | wr;
      burst = m_busy && (m_left > 0);
      fin   = m_busy && (m_left == 0);
      stl   = burst && req && STARVE && (m_wait == MAX_WAIT);
      grant = burst && (!req || stl);
      ea    = grant ? m_addr : a[8:0];
      check("mem_addr", o_mem_addr, ea);
      check("mem_we", o_mem_we, !grant && wr);
      if (!grant) check("mem_wdata", o_mem_wdata, wd);
      check("pipe_rdata", o_pipe_rdata, shadow[ea[8:2]]);
      check("pipe_stall", o_pipe_stall, stl);
      check("dbg_busy", o_dbg_busy, m_busy);
      check("dbg_valid", o_dbg_valid, m_valid);
      if (m_valid) check("dbg_data", o_dbg_data, m_data);
      check("dbg_done", o_dbg_done, fin);
      if (o_dbg_valid) dq.push_back(o_dbg_data);
      if (o_dbg_done) done_at = cyc;
      if (o_pipe_stall) stall_q.push_back(cyc);
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_left = 0; m_wait = 0; m_addr = '0; m_valid = 0; m_data = '0;
      end else begin
         m_valid = grant;
         if (grant) m_data = shadow[m_addr[8:2]];
         if (grant) begin
            m_addr = m_addr + 9'd4;
            m_left--;
            m_wait = 0;
         end else if (burst) begin
            m_wait++;
         end
         if (fin) begin
            m_busy = 0;
         end else if (!m_busy && st) begin
            m_busy = 1; m_addr = sa & 9'h1FC; m_left = int'(sl); m_wait = 0;
         end
      end
      if (!grant && wr) shadow[a[8:2]] = wd;
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, 0, 32'h0, 32'h0, 0, 9'h0, 8'h0, 0);
   endtask

   task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
      cycle(0, 1, a, d, 0, 9'h0, 8'h0, 0);
   endtask

   initial begin
      m_busy = 0; m_left = 0; m_wait = 0; m_addr = '0; m_valid = 0; m_data = '0;
      i_reset = 1; i_pipe_read = 0; i_pipe_write = 1; i_pipe_wdata = '0;
      i_dbg_start = 0; i_dbg_addr = '0; i_dbg_len = '0;
      for (int i = 0; i < 128; i++) begin
         shadow[i] = '0;
         i_pipe_addr = 32'(i * 4);
         @(posedge clk);
         #1;
      end
      i_pipe_write = 0;

      // reset state
      repeat (2) cycle(0, 0, 32'h0, 32'h0, 0, 9'h0, 8'h0, 1);
      check("rst_dbg_data", o_dbg_data, 32'h0);

      // idle-pipeline burst from an unaligned start
      wr_word(32'h10, 32'h11); wr_word(32'h14, 32'h22); wr_word(32'h18, 32'h33);
      dq.delete(); t0 = cyc;
      cycle(0, 0, 32'h0, 32'h0, 1, 9'h012, 8'd3, 0);
      idle(6);
      check("idle_count", dq.size(), 3);
      if (dq.size() == 3) begin
         check("idle_w0", dq[0], 32'h11); check("idle_w1", dq[1], 32'h22); check("idle_w2", dq[2], 32'h33);
      end
      check("idle_done_cyc", done_at - t0, 4);

      // interleave with pipeline loads on alternate cycles
      dq.delete(); t0 = cyc;
      cycle(0, 0, 32'h0, 32'h0, 1, 9'h012, 8'd3, 0);
      for (int i = 0; i < 8; i++) cycle(i % 2 == 0, 0, 32'h14, 32'h0, 0, 9'h0, 8'h0, 0);
      idle(2);
      check("ilv_count", dq.size(), 3);
      if (dq.size() == 3) begin
         check("ilv_w0", dq[0], 32'h11); check("ilv_w1", dq[1], 32'h22); check("ilv_w2", dq[2], 32'h33);
      end
      check("ilv_done_cyc", done_at - t0, 7);

      // wrap-around at the top of the address space
      wr_word(32'h1FC, 32'hAA); wr_word(32'h000, 32'hBB);
      dq.delete();
      cycle(0, 0, 32'h0, 32'h0, 1, 9'h1FC, 8'd2, 0);
      idle(4);
      check("wrap_count", dq.size(), 2);
      if (dq.size() == 2) begin
         check("wrap_w0", dq[0], 32'hAA); check("wrap_w1", dq[1], 32'hBB);
      end

      // zero-length burst
      dq.delete(); t0 = cyc;
      cycle(0, 0, 32'h0, 32'h0, 1, 9'h040, 8'd0, 0);
      idle(3);
      check("len0_done_cyc", done_at - t0, 1);
      check("len0_no_valid", dq.size(), 0);

      // start while busy is ignored
      dq.delete();
      cycle(0, 1, 32'h100, 32'h5, 1, 9'h020, 8'd3, 0);
      cycle(0, 1, 32'h104, 32'h6, 0, 9'h0, 8'h0, 0);
      cycle(0, 1, 32'h108, 32'h7, 1, 9'h080, 8'd1, 0);
      cycle(0, 1, 32'h10C, 32'h8, 0, 9'h0, 8'h0, 0);
      idle(6);
      check("busy_start_count", dq.size(), 3);

      // reset in the middle of a burst: no done pulse
      dq.delete(); done_at = -1;
      cycle(0, 0, 32'h0, 32'h0, 1, 9'h040, 8'd5, 0);
      idle(2);
      cycle(0, 0, 32'h0, 32'h0, 0, 9'h0, 8'h0, 1);
      idle(8);
      check("rst_mid_no_done", done_at, -1);
      check("rst_mid_words", dq.size(), 2);

      // constant pipeline stores against a waiting burst
      dq.delete(); stall_q.delete(); t0 = cyc;
      cycle(0, 1, 32'h180, 32'h1, 1, 9'h040, 8'd2, 0);
      for (int i = 0; i < 40; i++) cycle(0, 1, 32'h180 + 32'(4 * (i % 4)), $urandom, 0, 9'h0, 8'h0, 0);
      idle(5);
      check("starve_words", dq.size(), 2);
`ifdef DMEM_ARB_STARVE_EN
      check("starve_stalls", stall_q.size(), 2);
      if (stall_q.size() == 2) begin
         check("starve_first", stall_q[0] - t0, 16);
         check("starve_second", stall_q[1] - t0, 32);
      end
`else
      check("no_stalls", stall_q.size(), 0);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 3) == 0, ($urandom % 4) == 0, $urandom, $urandom,
               ($urandom % 8) == 0, 9'($urandom), 8'($urandom % 6), ($urandom % 150) == 0);
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
